// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback stage: load funct3 encodings,
// load-queue entry layout and arbitration state.
package regfile_wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic [31:0] data;
  } lq_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of ALU/LSU inputs and register-file write/forward outputs of the writeback stage.
// slave = the writeback stage itself, master = the surrounding pipeline.
interface regfile_writeback_if;
  logic        alu_valid_ip;
  logic [4:0]  alu_rd_ip;
  logic [31:0] alu_data_ip;
  logic        lsu_valid_ip;
  logic        lsu_ready_op;
  logic [4:0]  lsu_rd_ip;
  logic [2:0]  lsu_funct3_ip;
  logic [1:0]  lsu_offset_ip;
  logic [31:0] lsu_data_ip;
  logic        alu_stall_op;
  logic [31:0] wr_data_op;
  logic [4:0]  wr_port_op;
  logic        ctrl_reg_wr_en_op;
  logic        fwd_valid_op;
  logic [4:0]  fwd_port_op;
  logic [31:0] fwd_data_op;

  modport slave (
    input  alu_valid_ip, alu_rd_ip, alu_data_ip,
    input  lsu_valid_ip, lsu_rd_ip, lsu_funct3_ip, lsu_offset_ip, lsu_data_ip,
    output lsu_ready_op, alu_stall_op,
    output wr_data_op, wr_port_op, ctrl_reg_wr_en_op,
    output fwd_valid_op, fwd_port_op, fwd_data_op
  );

  modport master (
    output alu_valid_ip, alu_rd_ip, alu_data_ip,
    output lsu_valid_ip, lsu_rd_ip, lsu_funct3_ip, lsu_offset_ip, lsu_data_ip,
    input  lsu_ready_op, alu_stall_op,
    input  wr_data_op, wr_port_op, ctrl_reg_wr_en_op,
    input  fwd_valid_op, fwd_port_op, fwd_data_op
  );
endinterface

// File: rtl/regfile_wb_lq.sv
// Synchronous FIFO of pending load returns; push on full and pop on empty are ignored.
module regfile_wb_lq
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  lq_entry_t                din_i,
  input  logic                     pop_i,
  output lq_entry_t                dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  lq_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: arbitrates ALU results against queued load returns for the single
// register-file write port. Optional macro WB_FWD_EN adds a registered forward copy of each write.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int unsigned LQ_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  regfile_writeback_if.slave bus
);

  localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  lq_entry_t      lq_din, lq_head;
  logic           lq_push, lq_pop, lq_full, lq_empty;
  logic [CW-1:0]  lq_count;

  wb_state_e      state_q, state_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           sel_alu;
  logic           wr_en_q, wr_en_d;
  logic [4:0]     wr_port_q, wr_port_d;
  logic [31:0]    wr_data_q, wr_data_d;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {off, 3'b000});
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LBU:  return {24'h0, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'h0, h};
      F3_LW:   return d;
      default: return d;
    endcase
  endfunction

  assign lq_din = '{rd: bus.lsu_rd_ip, funct3: bus.lsu_funct3_ip,
                    offset: bus.lsu_offset_ip, data: bus.lsu_data_ip};
  assign bus.lsu_ready_op = (lq_count < CW'(LQ_DEPTH));
  assign lq_push          = bus.lsu_valid_ip & ~lq_full;

  regfile_wb_lq #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (lq_push),
    .din_i   (lq_din),
    .pop_i   (lq_pop),
    .dout_o  (lq_head),
    .full_o  (lq_full),
    .empty_o (lq_empty),
    .count_o (lq_count)
  );

  always_comb begin
    sel_alu   = 1'b0;
    lq_pop    = 1'b0;
    wr_en_d   = 1'b0;
    wr_port_d = wr_port_q;
    wr_data_d = wr_data_q;
    if (state_q == STALL)      lq_pop  = ~lq_empty;
    else if (bus.alu_valid_ip) sel_alu = 1'b1;
    else                       lq_pop  = ~lq_empty;

    // x0 writes still consume their slot and update port/data; only the enable is suppressed.
    if (sel_alu) begin
      wr_en_d   = (bus.alu_rd_ip != 5'd0);
      wr_port_d = bus.alu_rd_ip;
      wr_data_d = bus.alu_data_ip;
    end else if (lq_pop) begin
      wr_en_d   = (lq_head.rd != 5'd0);
      wr_port_d = lq_head.rd;
      wr_data_d = fmt_load(lq_head.funct3, lq_head.offset, lq_head.data);
    end

    starve_d = (lq_pop || lq_empty) ? '0 : starve_q + SW'(1);
    state_d  = NORMAL;
    if (state_q == NORMAL && starve_d == SW'(STARVE_MAX)) state_d = STALL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NORMAL;
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_port_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_port_q <= wr_port_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.alu_stall_op      = (state_q == STALL);
  assign bus.ctrl_reg_wr_en_op = wr_en_q;
  assign bus.wr_port_op        = wr_port_q;
  assign bus.wr_data_op        = wr_data_q;

`ifdef WB_FWD_EN
  logic        fwd_valid_q;
  logic [4:0]  fwd_port_q;
  logic [31:0] fwd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid_q <= 1'b0;
      fwd_port_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= wr_en_q;
      if (wr_en_q) begin
        fwd_port_q <= wr_port_q;
        fwd_data_q <= wr_data_q;
      end
    end
  end

  assign bus.fwd_valid_op = fwd_valid_q;
  assign bus.fwd_port_op  = fwd_port_q;
  assign bus.fwd_data_op  = fwd_data_q;
`else
  assign bus.fwd_valid_op = 1'b0;
  assign bus.fwd_port_op  = '0;
  assign bus.fwd_data_op  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed scoreboard bench for regfile_writeback: a behavioural arbitration model predicts
// each register-file write, which is compared one cycle later against the write port.
module tb_regfile_writeback;
  import regfile_wb_pkg::*;

  localparam int unsigned LQ     = 4;
  localparam int unsigned STARVE = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  typedef struct {
    logic        en;
    logic [4:0]  port;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_writeback_if bus ();

  regfile_writeback #(.LQ_DEPTH(LQ), .STARVE_MAX(STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  ld_t         mq[$];
  wr_t         exp_q[$];
  bit          m_stall  = 1'b0;
  int unsigned m_starve = 0;
  logic [4:0]  m_port   = '0;
  logic [31:0] m_data   = '0;
  wr_t         prev_wr  = '{1'b0, 5'd0, 32'd0};
  wr_t         last_fwd = '{1'b0, 5'd0, 32'd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_fmt(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
    logic [31:0] sb, sh;
    sb = d >> (8 * int'(off));
    sh = d >> (off[1] ? 16 : 0);
    case (f3)
      3'b000:  return 32'($signed(sb[7:0]));
      3'b100:  return sb & 32'h0000_00FF;
      3'b001:  return 32'($signed(sh[15:0]));
      3'b101:  return sh & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  task automatic check_write();
    wr_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      m_port = e.port;
      m_data = e.data;
    end else begin
      e = '{1'b0, m_port, m_data};
    end
    chk("wr_en",   bus.ctrl_reg_wr_en_op, e.en);
    chk("wr_port", bus.wr_port_op, e.port);
    chk("wr_data", bus.wr_data_op, e.data);
`ifdef WB_FWD_EN
    if (prev_wr.en) last_fwd = prev_wr;
    chk("fwd_valid", bus.fwd_valid_op, prev_wr.en);
    chk("fwd_port",  bus.fwd_port_op, last_fwd.port);
    chk("fwd_data",  bus.fwd_data_op, last_fwd.data);
`else
    chk("fwd_valid", bus.fwd_valid_op, 1'b0);
    chk("fwd_data",  bus.fwd_data_op, 32'd0);
`endif
    prev_wr = e;
  endtask

  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                      input logic [1:0] off, input logic [31:0] ld);
    int unsigned sz;
    bit popped;
    ld_t h;
    if (m_stall) av = 1'b0;
    bus.alu_valid_ip  = av;
    bus.alu_rd_ip     = ard;
    bus.alu_data_ip   = ad;
    bus.lsu_valid_ip  = lv;
    bus.lsu_rd_ip     = lrd;
    bus.lsu_funct3_ip = f3;
    bus.lsu_offset_ip = off;
    bus.lsu_data_ip   = ld;
    chk("alu_stall", bus.alu_stall_op, m_stall);
    chk("lsu_ready", bus.lsu_ready_op, mq.size() < LQ);
    vectors++;
    assert (!(bus.alu_valid_ip && bus.alu_stall_op))
    else begin
      miscompares++;
      $error("FAIL alu_in_stall: observed alu_valid=%b stall=%b", bus.alu_valid_ip, bus.alu_stall_op);
    end

    sz = mq.size();
    popped = 1'b0;
    if (!m_stall && av) exp_q.push_back('{ard != 5'd0, ard, ad});
    else if (sz != 0) begin
      h = mq.pop_front();
      popped = 1'b1;
      exp_q.push_back('{h.rd != 5'd0, h.rd, h.data});
    end
    if (lv && sz < LQ) mq.push_back('{lrd, model_fmt(f3, off, ld)});
    m_starve = (popped || sz == 0) ? 0 : m_starve + 1;
    m_stall  = !m_stall && (m_starve == STARVE);

    @(posedge clk);
    #1;
    check_write();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   bus.ctrl_reg_wr_en_op, 1'b0);
    chk({tag, "_wr_port"}, bus.wr_port_op, 5'd0);
    chk({tag, "_wr_data"}, bus.wr_data_op, 32'd0);
    chk({tag, "_stall"},   bus.alu_stall_op, 1'b0);
    chk({tag, "_ready"},   bus.lsu_ready_op, 1'b1);
    chk({tag, "_fwd_v"},   bus.fwd_valid_op, 1'b0);
    chk({tag, "_fwd_d"},   bus.fwd_data_op, 32'd0);
  endtask

  task automatic clear_model();
    mq.delete();
    exp_q.delete();
    m_stall  = 1'b0;
    m_starve = 0;
    m_port   = '0;
    m_data   = '0;
    prev_wr  = '{1'b0, 5'd0, 32'd0};
    last_fwd = '{1'b0, 5'd0, 32'd0};
  endtask

  initial begin
    bus.alu_valid_ip  = 1'b0;
    bus.alu_rd_ip     = '0;
    bus.alu_data_ip   = '0;
    bus.lsu_valid_ip  = 1'b0;
    bus.lsu_rd_ip     = '0;
    bus.lsu_funct3_ip = '0;
    bus.lsu_offset_ip = '0;
    bus.lsu_data_ip   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // ALU-only write and single-cycle pulse
    step(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    idle(1);

    // Loads with idle ALU
    step(0, 0, 0, 1, 5'd3, F3_LB, 2'd1, 32'h0000_80FF);
    idle(1);
    chk("lb_x3_direct", bus.wr_data_op, 32'hFFFF_FF80);
    step(0, 0, 0, 1, 5'd7, F3_LHU, 2'd2, 32'hABCD_1234);
    idle(1);
    chk("lhu_direct", bus.wr_data_op, 32'h0000_ABCD);
    step(0, 0, 0, 1, 5'd8, F3_LH, 2'd0, 32'h1234_8001);
    step(0, 0, 0, 1, 5'd9, F3_LBU, 2'd3, 32'hF0AA_BBCC);
    step(0, 0, 0, 1, 5'd10, 3'b011, 2'd1, 32'h5555_AAAA);
    step(0, 0, 0, 1, 5'd11, F3_LW, 2'd0, 32'h0BAD_F00D);
    idle(2);

    // Starvation: one queued load against continuous ALU traffic
    step(1, 5'd1, 32'h1000_0000, 1, 5'd12, F3_LW, 2'd0, 32'hCAFE_0001);
    for (int unsigned i = 0; i < 7; i++) step(1, 5'd2, 32'h2000_0000 + i, 0, 0, 0, 0, 0);

    // Full queue under continuous ALU traffic; the fifth push is refused
    for (int unsigned i = 0; i < 5; i++)
      step(1, 5'd4, 32'h3000_0000 + i, 1, 5'(13 + i), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), $urandom);
    for (int unsigned i = 0; i < 6; i++) step(1, 5'd6, 32'h4000_0000 + i, 0, 0, 0, 0, 0);
    idle(5);

    // Writes to x0
    step(1, 5'd0, 32'h7777_7777, 1, 5'd0, F3_LW, 2'd0, 32'h8888_8888);
    idle(2);

    // Reset with three queued loads and a write in flight
    for (int unsigned i = 0; i < 3; i++)
      step(1, 5'd20, 32'h5000_0000 + i, 1, 5'(21 + i), F3_LW, 2'd0, 32'h6000_0000 + i);
    rst = 1'b1;
    #2;
    check_reset_outputs("midreset");
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    step(1, 5'd30, 32'h1234_5678, 0, 0, 0, 0, 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
